core_run_ctrl: RTL and testbench
================================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter PC_W, default 32, width of the monitored program counter.
REQ-002 Parameter CNT_W, default 32, width of the run cycle counter.
REQ-003 Parameter RESET_CYCLES, default 1, number of cycles core_reset is held after start; legal range 1..255.
REQ-004 Parameter MAX_CYCLES, default 50, RUN-cycle budget before timeout; 1..2^CNT_W-1.
REQ-005 Parameter HALT_REPEAT, default 4, consecutive unchanged-PC cycles that count as halt; 0 disables PC halt detection.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle request to (re)launch the core.
REQ-009 pc  input  PC_W  current core program counter.
REQ-010 halt_req  input  1  core-side halt indication, e.g. ebreak retired.
REQ-011 core_reset  output  1  active-high reset driven to the core.
REQ-012 imem_read_en  output  1  instruction memory read enable driven to the core.
REQ-013 busy  output  1  high in HOLD and RUN.
REQ-014 done  output  1  high in HALTED and TIMEOUT.
REQ-015 timeout  output  1  high in TIMEOUT only.
REQ-016 cycle_count  output  CNT_W  RUN cycles elapsed in the current or last run.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, RUN, HALTED, TIMEOUT; all outputs registered, so a transition becomes visible the cycle after its cause.
REQ-018 IDLE: core_reset=1, imem_read_en=0; start=1 -> HOLD, hold counter loaded with RESET_CYCLES.
REQ-019 HOLD: core_reset=1, imem_read_en=1, cycle_count cleared to 0; after exactly RESET_CYCLES cycles in HOLD -> RUN.
REQ-020 RUN: core_reset=0, imem_read_en=1, cycle_count increments by 1 every RUN cycle.
REQ-021 RUN: halt_req=1 -> HALTED; cycle_count includes the halting cycle.
REQ-022 RUN: repeat counter increments when pc equals pc from the previous RUN cycle, else clears; reaching HALT_REPEAT -> HALTED.
REQ-023 The first RUN cycle SHALL NOT be compared; it only captures pc.
REQ-024 RUN: cycle_count reaching MAX_CYCLES -> TIMEOUT; cycle_count never exceeds MAX_CYCLES.
REQ-025 Halt (halt_req or PC repeat) and timeout in the same cycle SHALL resolve to HALTED.
REQ-026 HALTED: core_reset=0, imem_read_en=0, done=1, cycle_count frozen.
REQ-027 TIMEOUT: core_reset=0, imem_read_en=0, done=1, timeout=1, cycle_count frozen at MAX_CYCLES.
REQ-028 start in HALTED or TIMEOUT -> HOLD (rerun); done and timeout clear with the transition.
REQ-029 start in HOLD or RUN SHALL be ignored.
REQ-030 halt_req and pc SHALL be ignored outside RUN.

Reset
REQ-031 reset=0 SHALL immediately, independent of clk, force IDLE: core_reset=1, imem_read_en=0, busy=0, done=0, timeout=0, cycle_count=0, hold and repeat counters and captured pc cleared.
REQ-032 reset asserted mid-run SHALL abort the run with no done or timeout indication; after release the block waits in IDLE for start.
REQ-033 start sampled in the first edge after reset release SHALL be honoured.

Verification
REQ-034 Reset then start, RESET_CYCLES=1, halt_req=0, pc incrementing by 4 -> core_reset high for 1 cycle after start, then RUN; at MAX_CYCLES=50, TIMEOUT with timeout=1, done=1, cycle_count=50, imem_read_en=0.
REQ-035 pc advancing for 10 RUN cycles, then held at 0x0000_0028 with HALT_REPEAT=4 -> HALTED 4 cycles after the first repeat, done=1, timeout=0, cycle_count=14.
REQ-036 halt_req pulsed on RUN cycle 7 -> HALTED, cycle_count=7; halt_req on RUN cycle 50 with MAX_CYCLES=50 -> HALTED, not TIMEOUT.
REQ-037 reset driven low between clock edges on RUN cycle 20 -> outputs reach reset values before the next edge; start pulses ignored until reset=1.
REQ-038 start in HALTED -> HOLD with cycle_count=0 and done=0; start pulsed during HOLD and RUN -> no state change; RESET_CYCLES=3 -> core_reset high exactly 3 cycles.
REQ-039 HALT_REPEAT=0 with pc held constant -> no PC halt; TIMEOUT at MAX_CYCLES.

Source files
------------

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - core launch/run supervisor: reset hold, run budget, halt and timeout detection
// Sequences IDLE -> HOLD -> RUN -> HALTED/TIMEOUT; every output is a flop.
module core_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 50,
  parameter int HALT_REPEAT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_req,
  output logic             core_reset,
  output logic             imem_read_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RPT_W = $clog2(HALT_REPEAT + 2);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       HOLD_INIT = 8'(RESET_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LIMIT = RPT_W'(HALT_REPEAT);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam bit               RPT_EN    = (HALT_REPEAT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             core_reset_q;
  logic             imem_read_en_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;

  logic [CNT_W-1:0] cnt_inc;
  logic [RPT_W-1:0] rpt_inc;
  logic             rpt_hit;

  // The first RUN cycle only captures pc, so it can never count as a repeat.
  always_comb begin
    cnt_inc = cnt_q + CNT_ONE;
    rpt_inc = (!first_q && (pc == pc_q)) ? (rpt_q + RPT_ONE) : '0;
    rpt_hit = RPT_EN && (rpt_inc == RPT_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rpt_d   = rpt_q;
    pc_d    = pc_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_d = S_HOLD;
          hold_d  = HOLD_INIT;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        hold_d = hold_q - 8'd1;
        if (hold_q == 8'd1) begin
          state_d = S_RUN;
          first_d = 1'b1;
          rpt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d   = cnt_inc;
        pc_d    = pc;
        first_d = 1'b0;
        rpt_d   = rpt_inc;
        // A halt on the budget's last cycle wins over the timeout.
        if (halt_req || rpt_hit) begin
          state_d = S_HALTED;
        end else if (cnt_inc == MAX_CNT) begin
          state_d = S_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      hold_q         <= '0;
      rpt_q          <= '0;
      pc_q           <= '0;
      first_q        <= 1'b0;
      cnt_q          <= '0;
      core_reset_q   <= 1'b1;
      imem_read_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      rpt_q          <= rpt_d;
      pc_q           <= pc_d;
      first_q        <= first_d;
      cnt_q          <= cnt_d;
      core_reset_q   <= (state_d == S_IDLE) || (state_d == S_HOLD);
      imem_read_en_q <= (state_d == S_HOLD) || (state_d == S_RUN);
      busy_q         <= (state_d == S_HOLD) || (state_d == S_RUN);
      done_q         <= (state_d == S_HALTED) || (state_d == S_TIMEOUT);
      timeout_q      <= (state_d == S_TIMEOUT);
    end
  end

  assign core_reset   = core_reset_q;
  assign imem_read_en = imem_read_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - randomized bench for core_run_ctrl against a behavioural run model
// Two instances with different hold/halt parameters are checked every cycle.
module tb_core_run_ctrl;

  localparam int MAXC = 50;
  localparam int M_IDLE = 0, M_HOLD = 1, M_RUN = 2, M_HALTED = 3, M_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc_a = '0, pc_b = '0;
  logic        halt_a = 1'b0, halt_b = 1'b0;

  logic        cr_a, ie_a, busy_a, done_a, to_a;
  logic        cr_b, ie_b, busy_b, done_b, to_b;
  logic [31:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(3), .MAX_CYCLES(MAXC), .HALT_REPEAT(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .pc(pc_a), .halt_req(halt_a),
    .core_reset(cr_a), .imem_read_en(ie_a), .busy(busy_a), .done(done_a),
    .timeout(to_a), .cycle_count(cnt_a)
  );

  core_run_ctrl #(.PC_W(32), .CNT_W(32), .RESET_CYCLES(1), .MAX_CYCLES(MAXC), .HALT_REPEAT(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .pc(pc_b), .halt_req(halt_b),
    .core_reset(cr_b), .imem_read_en(ie_b), .busy(busy_b), .done(done_b),
    .timeout(to_b), .cycle_count(cnt_b)
  );

  // Reference model: which phase each core is in and how long it has run.
  int          ph[2];
  int          hold_left[2];
  int          run_n[2];
  int          cnt[2];
  int          since[2];
  logic [31:0] last_pc[2];
  int          rc[2] = '{3, 1};
  int          hr[2] = '{4, 0};

  int mode = 0;
  int halt_at = 0;
  bit halt_rand = 1'b0;
  bit start_rand = 1'b0;

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = M_IDLE; hold_left[m] = 0; run_n[m] = 0; cnt[m] = 0; since[m] = 0; last_pc[m] = '0;
    end
  endtask

  task automatic model_step(input int m, input logic st, input logic [31:0] p, input logic h);
    bit halt;
    case (ph[m])
      M_IDLE, M_HALTED, M_TIMEOUT: begin
        if (st) begin ph[m] = M_HOLD; hold_left[m] = rc[m]; cnt[m] = 0; end
      end
      M_HOLD: begin
        hold_left[m]--;
        if (hold_left[m] == 0) begin ph[m] = M_RUN; run_n[m] = 0; end
      end
      default: begin
        run_n[m]++;
        cnt[m] = run_n[m];
        if (run_n[m] == 1 || p != last_pc[m]) since[m] = run_n[m];
        last_pc[m] = p;
        halt = h || (hr[m] > 0 && (run_n[m] - since[m]) >= hr[m]);
        if (halt) ph[m] = M_HALTED;
        else if (cnt[m] == MAXC) ph[m] = M_TIMEOUT;
      end
    endcase
  endtask

  function automatic logic [36:0] exp_vec(input int m);
    logic c, i, b, d, t;
    c = (ph[m] == M_IDLE) || (ph[m] == M_HOLD);
    i = (ph[m] == M_HOLD) || (ph[m] == M_RUN);
    b = i;
    d = (ph[m] == M_HALTED) || (ph[m] == M_TIMEOUT);
    t = (ph[m] == M_TIMEOUT);
    return {c, i, b, d, t, 32'(cnt[m])};
  endfunction

  function automatic logic [31:0] pc_for(input int m);
    int k;
    if (ph[m] != M_RUN) return $urandom;
    k = run_n[m] + 1;
    case (mode)
      0: return 32'(4 * k);
      1: return 32'(4 * ((k < 10) ? k : 10));
      2: return 32'h100;
      default: return 32'($urandom_range(0, 3) * 4);
    endcase
  endfunction

  function automatic logic halt_for(input int m);
    int k;
    if (ph[m] != M_RUN) return 1'($urandom_range(0, 1));
    k = run_n[m] + 1;
    return (k == halt_at) || (halt_rand && ($urandom_range(0, 29) == 0));
  endfunction

  task automatic drive();
    pc_a   = pc_for(0);
    pc_b   = pc_for(1);
    halt_a = halt_for(0);
    halt_b = halt_for(1);
    start  = start_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_step(0, start, pc_a, halt_a);
      model_step(1, start, pc_b, halt_b);
    end
    @(negedge clk);
    check("cyc_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, exp_vec(0));
    check("cyc_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, exp_vec(1));
    drive();
  endtask

  task automatic scenario(input int md, input int hat, input bit hrn, input bit srn, input int n);
    mode = md; halt_at = hat; halt_rand = hrn; start_rand = srn;
    start = 1'b1;
    repeat (n) tick();
  endtask

  // Pulls reset low between edges and checks outputs before the next edge.
  task automatic async_reset(input int low_ticks);
    #2 reset = 1'b0;
    #1 model_reset();
    check("rst_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b10000, 32'd0});
    check("rst_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b10000, 32'd0});
    repeat (low_ticks) begin
      tick();
      start = 1'b1;
    end
    reset = 1'b1;
    start = 1'b1;
  endtask

  initial begin
    int crs_a, crs_b, guard;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check("por_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b10000, 32'd0});
    check("por_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b10000, 32'd0});
    repeat (2) tick();

    // Start on the first edge after release; pc steps by 4, no halt.
    mode = 0; halt_at = 0; halt_rand = 0; start_rand = 0;
    reset = 1'b1; start = 1'b1;
    crs_a = 0; crs_b = 0;
    repeat (70) begin
      tick();
      crs_a += int'(cr_a);
      crs_b += int'(cr_b);
    end
    check("hold_len_a", 37'(crs_a), 37'd3);
    check("hold_len_b", 37'(crs_b), 37'd1);
    check("tmo_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00011, 32'd50});
    check("tmo_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b00011, 32'd50});

    scenario(1, 0, 0, 0, 70);
    check("pc_halt_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00010, 32'd14});
    check("no_pc_halt_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b00011, 32'd50});

    mode = 0; start = 1'b1;
    tick();
    check("rerun_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b11100, 32'd0});
    check("rerun_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b11100, 32'd0});
    start_rand = 1'b1;
    repeat (60) tick();
    start_rand = 1'b0;
    repeat (70) tick();

    scenario(2, 0, 0, 0, 70);
    check("const_pc_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00010, 32'd5});
    check("const_pc_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b00011, 32'd50});

    scenario(0, 7, 0, 0, 60);
    check("halt7_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00010, 32'd7});
    check("halt7_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b00010, 32'd7});

    scenario(0, 50, 0, 0, 70);
    check("halt50_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00010, 32'd50});
    check("halt50_b", {cr_b, ie_b, busy_b, done_b, to_b, cnt_b}, {5'b00010, 32'd50});

    // Abort on RUN cycle 20 of instance A.
    mode = 0; halt_at = 0; start = 1'b1;
    guard = 0;
    while (!(ph[0] == M_RUN && run_n[0] == 19) && guard < 200) begin
      tick();
      guard++;
    end
    check("reach_run20", 37'(guard < 200), 37'd1);
    async_reset(4);
    repeat (60) tick();
    check("after_rst_a", {cr_a, ie_a, busy_a, done_a, to_a, cnt_a}, {5'b00011, 32'd50});

    for (int it = 0; it < 25; it++) begin
      scenario($urandom_range(0, 3), $urandom_range(0, 60), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(20, 80));
      if ($urandom_range(0, 4) == 0) begin
        async_reset($urandom_range(1, 3));
        repeat (10) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
